stage_sequencer: RTL and testbench



---
 rtl/stage_seq_pkg.sv | 32 +++
 rtl/stage_sequencer_lfsr8.sv | 32 +++
 rtl/stage_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_seq_pkg.sv
// -----------------------------------------------------------------------------
// stage_seq_pkg
// Shared definitions for the stage sequencer: FSM state encoding, key-index
// width for the default key count, LFSR tap mask, default LFSR seed and the
// LFSR next-state helper.
// -----------------------------------------------------------------------------
package stage_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_SHOW_ON,
        ST_SHOW_GAP,
        ST_INPUT,
        ST_WAIT_ACK,
        ST_DONE,
        ST_FAIL
    } state_t;

    localparam int DEF_NUM_KEYS = 4;
    localparam int KEY_W        = $clog2(DEF_NUM_KEYS);

    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] DEF_LFSR_SEED = 8'hA5;

    // Fibonacci step: shift left, XOR of the tapped bits enters at bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/stage_sequencer_lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// Free-running 8-bit Fibonacci LFSR. No enable: it advances on every clock and
// reloads SEED while reset is high.
// Ports:
//   clk   in  rising-edge clock
//   reset in  asynchronous active-high reset (loads SEED)
//   q     out current LFSR value
// -----------------------------------------------------------------------------
module lfsr8
    import stage_seq_pkg::*;
#(
    parameter logic [7:0] SEED = DEF_LFSR_SEED
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);

    logic [7:0] lfsr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign q = lfsr_reg;

endmodule

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
// Producer side of the stage-clear protocol. Generates a pseudo-random key
// sequence, plays the first `level` entries on the LEDs, then checks player
// key presses against it. Every correct press emits a one-cycle true_stack
// pulse; the checker answers with clear (next level) or allclear (game over).
// Ports:
//   clk        in  rising-edge clock
//   reset      in  asynchronous active-high reset
//   start      in  start/restart request, honoured in IDLE/DONE/FAIL only
//   key_valid  in  one-cycle key-press strobe
//   key_idx    in  pressed key index
//   clear      in  level cleared (honoured in WAIT_ACK only)
//   allclear   in  final level cleared (honoured in WAIT_ACK only)
//   stage      out thermometer mask (1<<level)-1
//   true_stack out one-cycle pulse per correct key
//   led        out one-hot playback display
//   level      out current level, 0 when idle
//   busy       out high outside IDLE/DONE/FAIL
//   fail       out sticky wrong-key flag
// -----------------------------------------------------------------------------
module stage_sequencer
    import stage_seq_pkg::*;
#(
    parameter int         NUM_STEPS   = 5,
    parameter int         NUM_KEYS    = 4,
    parameter int         SHOW_CYCLES = 8,
    parameter int         GAP_CYCLES  = 2,
    parameter logic [7:0] LFSR_SEED   = DEF_LFSR_SEED
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        key_valid,
    input  logic [$clog2(NUM_KEYS)-1:0] key_idx,
    input  logic                        clear,
    input  logic                        allclear,
    output logic [NUM_STEPS-1:0]        stage,
    output logic                        true_stack,
    output logic [NUM_KEYS-1:0]         led,
    output logic [2:0]                  level,
    output logic                        busy,
    output logic                        fail
);

    localparam int KW    = $clog2(NUM_KEYS);
    localparam int CNT_W = $clog2(SHOW_CYCLES + GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       LAST_LEVEL = 3'(NUM_STEPS);

    state_t                state_reg;
    logic [2:0]            idx_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [2:0]            level_reg;
    logic [NUM_STEPS-1:0]  stage_reg;
    logic [NUM_KEYS-1:0]   led_reg;
    logic                  true_stack_reg;
    logic                  busy_reg;
    logic                  fail_reg;

    logic [KW-1:0]         seq_reg [NUM_STEPS];

    logic [7:0]            lfsr_q;
    logic [KW-1:0]         key_entry;
    logic                  unused_lfsr_bits;

    logic [2:0]            idx_inc;
    logic [KW-1:0]         seq_at_idx;
    logic [KW-1:0]         seq_at_inc;
    logic [KW-1:0]         seq_first;
    logic                  last_idx;

    // ------------------------------------------------------------------
    // Key source
    // ------------------------------------------------------------------
    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign key_entry        = lfsr_q[KW-1:0];
    assign unused_lfsr_bits = ^lfsr_q[7:KW];

    // ------------------------------------------------------------------
    // Sequence storage: entry gi is written on the GEN clock whose write
    // pointer equals gi. Contents are don't-care until the first GEN.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STEPS; gi++) begin : g_seq
            always_ff @(posedge clk) begin
                if (state_reg == ST_GEN && idx_reg == 3'(gi)) begin
                    seq_reg[gi] <= key_entry;
                end
            end
        end
    endgenerate

    assign idx_inc  = idx_reg + 3'd1;
    assign last_idx = (idx_reg == level_reg - 3'd1);

    // Read muxes for the current step and the step about to be shown next.
    always_comb begin
        seq_at_idx = '0;
        seq_at_inc = '0;
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (idx_reg == 3'(i)) begin
                seq_at_idx = seq_reg[i];
            end
            if (idx_inc == 3'(i)) begin
                seq_at_inc = seq_reg[i];
            end
        end
    end

    // On the final GEN clock seq[0] is already stored unless the sequence
    // is a single entry, in which case it is being written right now.
    assign seq_first = (idx_reg == 3'd0) ? key_entry : seq_reg[0];

    function automatic logic [NUM_KEYS-1:0] onehot(input logic [KW-1:0] k);
        logic [NUM_KEYS-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Control FSM. The LED is loaded on the clock that enters SHOW_ON so
    // that it is lit for exactly SHOW_CYCLES clocks.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            cnt_reg        <= '0;
            level_reg      <= '0;
            stage_reg      <= '0;
            led_reg        <= '0;
            true_stack_reg <= 1'b0;
            busy_reg       <= 1'b0;
            fail_reg       <= 1'b0;
        end else begin
            true_stack_reg <= 1'b0;

            case (state_reg)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        state_reg <= ST_GEN;
                        idx_reg   <= '0;
                        cnt_reg   <= '0;
                        level_reg <= 3'd1;
                        stage_reg <= NUM_STEPS'(1);
                        led_reg   <= '0;
                        busy_reg  <= 1'b1;
                        fail_reg  <= 1'b0;
                    end
                end

                ST_GEN: begin
                    if (idx_reg == LAST_LEVEL - 3'd1) begin
                        state_reg <= ST_SHOW_ON;
                        idx_reg   <= '0;
                        cnt_reg   <= '0;
                        led_reg   <= onehot(seq_first);
                    end else begin
                        idx_reg <= idx_inc;
                    end
                end

                ST_SHOW_ON: begin
                    if (cnt_reg == SHOW_LAST) begin
                        state_reg <= ST_SHOW_GAP;
                        cnt_reg   <= '0;
                        led_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_SHOW_GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        cnt_reg <= '0;
                        if (last_idx) begin
                            state_reg <= ST_INPUT;
                            idx_reg   <= '0;
                        end else begin
                            state_reg <= ST_SHOW_ON;
                            idx_reg   <= idx_inc;
                            led_reg   <= onehot(seq_at_inc);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_INPUT: begin
                    if (key_valid) begin
                        if (key_idx == seq_at_idx) begin
                            true_stack_reg <= 1'b1;
                            if (last_idx) begin
                                state_reg <= ST_WAIT_ACK;
                                idx_reg   <= '0;
                            end else begin
                                idx_reg <= idx_inc;
                            end
                        end else begin
                            state_reg <= ST_FAIL;
                            fail_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end
                    end
                end

                ST_WAIT_ACK: begin
                    // A clear on the final level is as good as allclear, so
                    // level/stage can never run past NUM_STEPS.
                    if (allclear || (clear && level_reg == LAST_LEVEL)) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                    end else if (clear) begin
                        state_reg <= ST_SHOW_ON;
                        level_reg <= level_reg + 3'd1;
                        stage_reg <= {stage_reg[NUM_STEPS-2:0], 1'b1};
                        idx_reg   <= '0;
                        cnt_reg   <= '0;
                        led_reg   <= onehot(seq_reg[0]);
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign stage      = stage_reg;
    assign true_stack = true_stack_reg;
    assign led        = led_reg;
    assign level      = level_reg;
    assign busy       = busy_reg;
    assign fail       = fail_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
// Randomized bench with a behavioural game model: the model tracks the game
// phase, elapsed playback time, keys entered and the LFSR as plain integers,
// and a negedge process compares every output against it each cycle.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

    localparam int P_IDLE  = 0;
    localparam int P_GEN   = 1;
    localparam int P_PLAY  = 2;
    localparam int P_INPUT = 3;
    localparam int P_WAIT  = 4;
    localparam int P_DONE  = 5;
    localparam int P_FAIL  = 6;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       start     = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key_idx   = 2'd0;
    logic       clear     = 1'b0;
    logic       allclear  = 1'b0;
    logic [4:0] stage;
    logic       true_stack;
    logic [3:0] led;
    logic [2:0] level;
    logic       busy;
    logic       fail;

    always #5 clk = ~clk;

    stage_sequencer #(
        .NUM_STEPS   (5),
        .NUM_KEYS    (4),
        .SHOW_CYCLES (8),
        .GAP_CYCLES  (2),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_valid  (key_valid),
        .key_idx    (key_idx),
        .clear      (clear),
        .allclear   (allclear),
        .stage      (stage),
        .true_stack (true_stack),
        .led        (led),
        .level      (level),
        .busy       (busy),
        .fail       (fail)
    );

    // ---------------- behavioural model ----------------
    int m_phase   = P_IDLE;
    int m_lfsr    = 8'hA5;
    int m_level   = 0;
    int m_gcnt    = 0;
    int m_t       = 0;
    int m_entered = 0;
    bit m_busy    = 1'b0;
    bit m_fail    = 1'b0;
    bit m_ts      = 1'b0;
    int m_seq[5]  = '{0, 0, 0, 0, 0};

    int  vectors     = 0;
    int  miscompares = 0;
    int  pulses      = 0;
    bit  done_sim    = 1'b0;
    int  exp_seq[5]  = '{2, 0, 1, 3, 3};

    function automatic int parity8(input int v);
        int p = 0;
        for (int i = 0; i < 8; i++) p += (v >> i) & 1;
        return p % 2;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = P_IDLE; m_lfsr = 8'hA5; m_level = 0; m_gcnt = 0;
            m_t = 0; m_entered = 0; m_busy = 0; m_fail = 0; m_ts = 0;
        end else begin
            m_ts = 0;
            case (m_phase)
                P_IDLE, P_DONE, P_FAIL: if (start) begin
                    m_phase = P_GEN; m_gcnt = 0; m_level = 1; m_fail = 0; m_busy = 1;
                end
                P_GEN: begin
                    m_seq[m_gcnt] = m_lfsr % 4;
                    m_gcnt++;
                    if (m_gcnt == 5) begin m_phase = P_PLAY; m_t = 0; end
                end
                P_PLAY: begin
                    m_t++;
                    if (m_t == m_level * 10) begin m_phase = P_INPUT; m_entered = 0; end
                end
                P_INPUT: if (key_valid) begin
                    if (int'(key_idx) == m_seq[m_entered]) begin
                        m_ts = 1;
                        m_entered++;
                        if (m_entered == m_level) m_phase = P_WAIT;
                    end else begin
                        m_phase = P_FAIL; m_fail = 1; m_busy = 0;
                    end
                end
                P_WAIT: begin
                    if (allclear || (clear && m_level == 5)) begin
                        m_phase = P_DONE; m_busy = 0;
                    end else if (clear) begin
                        m_level++; m_phase = P_PLAY; m_t = 0;
                    end
                end
                default: ;
            endcase
            m_lfsr = ((m_lfsr << 1) & 255) | parity8(m_lfsr & 8'hB8);
        end
    end

    function automatic int exp_led();
        if (m_phase == P_PLAY && (m_t % 10) < 8) return 1 << m_seq[m_t / 10];
        return 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!done_sim) begin
            chk("led", int'(led), exp_led());
            chk("stage", int'(stage), (1 << m_level) - 1);
            chk("level", int'(level), m_level);
            chk("busy", int'(busy), int'(m_busy));
            chk("fail", int'(fail), int'(m_fail));
            chk("true_stack", int'(true_stack), int'(m_ts));
            if (true_stack) pulses++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with random inputs that must be ignored in the current phase.
    task automatic noisy_tick();
        if (m_phase == P_PLAY || m_phase == P_GEN) begin
            key_valid = ($urandom_range(0, 3) == 0);
            key_idx   = 2'($urandom_range(0, 3));
        end
        if (m_phase != P_WAIT) begin
            clear    = ($urandom_range(0, 5) == 0);
            allclear = ($urandom_range(0, 7) == 0);
        end
        tick();
        key_valid = 0; clear = 0; allclear = 0;
    endtask

    task automatic wait_phase(input int p, input int budget);
        int n = 0;
        while (m_phase != p && n < budget) begin
            noisy_tick();
            n++;
        end
        if (m_phase != p) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: phase %0d required %0d", m_phase, p);
        end
    endtask

    task automatic press(input int k);
        key_valid = 1; key_idx = 2'(k);
        tick();
        key_valid = 0;
        repeat ($urandom_range(0, 3)) noisy_tick();
    endtask

    task automatic play_level_correct();
        wait_phase(P_INPUT, 400);
        for (int i = 0; i < m_level; i++) press(m_seq[i]);
    endtask

    task automatic start_game();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic pulse_clear();
        clear = 1;
        tick();
        clear = 0;
    endtask

    // Same start timing after reset release every time it is used.
    task automatic reset_then_start();
        reset = 1;
        repeat (3) tick();
        reset = 0;
        chk("rst_stage", int'(stage), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_busy", int'(busy), 0);
        tick(); tick();
        start_game();
        chk("start_busy", int'(busy), 1);
        chk("start_level", int'(level), 1);
        chk("start_stage", int'(stage), 1);
        repeat (4) tick();
        chk("gen_dark", int'(led), 0);
        tick();
        chk("first_led", int'(led), 4);
        for (int i = 0; i < 5; i++) chk("seq_literal", m_seq[i], exp_seq[i]);
    endtask

    // ---------------- scenario ----------------
    initial begin
        int p0;
        int wrong;

        reset_then_start();
        repeat (7) tick();
        chk("led_on_8th", int'(led), 4);
        tick();
        chk("led_gap", int'(led), 0);
        wait_phase(P_INPUT, 10);

        // clear during INPUT is ignored
        pulse_clear();
        chk("clear_in_input_level", int'(level), 1);

        p0 = pulses;
        press(m_seq[0]);
        tick();
        chk("l1_pulses", pulses - p0, 1);
        pulse_clear();
        chk("l2_level", int'(level), 2);
        chk("l2_stage", int'(stage), 3);

        // key during SHOW_ON is ignored
        repeat (2) tick();
        key_valid = 1; key_idx = 2'(m_seq[0]);
        tick();
        key_valid = 0;
        chk("key_in_show_ts", int'(true_stack), 0);

        play_level_correct();
        pulse_clear();

        // level 3: two right, one wrong
        wait_phase(P_INPUT, 400);
        p0 = pulses;
        press(m_seq[0]);
        press(m_seq[1]);
        press((m_seq[2] + 1) % 4);
        tick();
        chk("l3_pulses", pulses - p0, 2);
        chk("l3_fail", int'(fail), 1);
        chk("l3_busy", int'(busy), 0);
        chk("l3_level_hold", int'(level), 3);
        start_game();
        chk("restart_fail", int'(fail), 0);
        chk("restart_level", int'(level), 1);

        // full game to level 5
        for (int lv = 1; lv < 5; lv++) begin
            play_level_correct();
            pulse_clear();
        end
        wait_phase(P_INPUT, 400);
        p0 = pulses;
        play_level_correct();
        tick();
        chk("l5_pulses", pulses - p0, 5);
        clear = 1; allclear = 1;
        tick();
        clear = 0; allclear = 0;
        chk("done_busy", int'(busy), 0);
        chk("done_stage", int'(stage), 31);
        chk("done_level", int'(level), 5);

        // reset during SHOW_ON at level 2
        start_game();
        play_level_correct();
        pulse_clear();
        repeat (3) tick();
        reset = 1;
        #1;
        chk("async_led", int'(led), 0);
        chk("async_stage", int'(stage), 0);
        chk("async_level", int'(level), 0);
        reset_then_start();

        // randomized games
        for (int g = 0; g < 6; g++) begin
            if (g > 0) start_game();
            while (m_phase != P_DONE && m_phase != P_FAIL) begin
                wait_phase(P_INPUT, 400);
                if (m_phase != P_INPUT) break;
                for (int i = 0; i < m_level && m_phase == P_INPUT; i++) begin
                    if ($urandom_range(0, 11) == 0) begin
                        wrong = (m_seq[i] + $urandom_range(1, 3)) % 4;
                        press(wrong);
                    end else begin
                        press(m_seq[i]);
                    end
                end
                if (m_phase == P_WAIT) begin
                    repeat ($urandom_range(0, 3)) noisy_tick();
                    case ($urandom_range(0, 5))
                        0:       allclear = 1;
                        1:       begin clear = 1; allclear = 1; end
                        default: clear = 1;
                    endcase
                    tick();
                    clear = 0; allclear = 0;
                end
            end
            repeat (2) noisy_tick();
        end

        done_sim = 1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
